// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_ctrl_pkg
// Description : Shared definitions for the counter sweep controller: sweep
//               FSM state encoding and the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter
// Description : Loadable up/down counter, synchronous priority
//               clear > load > count.
// Ports       : clk, rst   - clock, asynchronous active-high reset
//               clear      - synchronous clear to zero
//               load, data - synchronous load of data
//               en, inc    - count enable; inc=1 counts up, 0 counts down
//               count      - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic             inc,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= data;
    end else if (en) begin
      count <= inc ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_sweep_ctrl
// Description : Sweep sequencer around an up/down counter. A job loads the
//               counter with a start value, then steps it one per cycle
//               toward the end value and pulses done. Supports pause and
//               abort (abort wins over everything and clears the counter).
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               start_i             - job request (honoured only in IDLE)
//               start_val, end_val  - job bounds
//               pause_i             - freezes stepping while high in RUN
//               abort_i             - cancels job, clears counter
//               busy                - high in LOAD and RUN
//               done                - one-cycle pulse in DONE
//               aborted             - one-cycle pulse after a taken abort
//               count_o             - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sweep_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] count_o
);

  state_t           state;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] end_q;
  logic             dir_up;
  logic [WIDTH-1:0] count;
  logic             at_end;

  logic             cnt_clear;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_inc;
  logic [WIDTH-1:0] cnt_data;

  assign at_end  = (count == end_q);
  assign count_o = count;

  // Counter controls are decoded straight from state so the counter acts on
  // the very next edge. Clear also outranks load/count inside the counter;
  // gating load/en on abort just keeps the control set unambiguous.
  always_comb begin
    cnt_clear = abort_i;
    cnt_load  = (state == LOAD) && !abort_i;
    cnt_en    = (state == RUN) && !at_end && !pause_i && !abort_i;
    cnt_inc   = dir_up;
    cnt_data  = start_q;
  end

  // Outputs are registered from the next state, so busy/done follow the
  // state they describe with no combinational path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= '0;
      end_q   <= '0;
      dir_up  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort_i) begin
        state   <= IDLE;
        busy    <= 1'b0;
        // An abort in IDLE has no job to cancel, so it is silent.
        aborted <= (state != IDLE);
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              start_q <= start_val;
              end_q   <= end_val;
              dir_up  <= (end_val >= start_val);
              state   <= LOAD;
              busy    <= 1'b1;
            end
          end
          LOAD: begin
            state <= RUN;
            busy  <= 1'b1;
          end
          RUN: begin
            if (at_end) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              busy  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .load  (cnt_load),
    .en    (cnt_en),
    .inc   (cnt_inc),
    .data  (cnt_data),
    .count (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sweep_ctrl
// Description : Directed self-checking bench for counter_sweep_ctrl.
//               Cycle k of a job is the clock period that follows edge k-1,
//               with the job accepted at edge 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sweep_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;
  logic             pause_i;
  logic             abort_i;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] count_o;

  int n_checks = 0;
  int n_fail   = 0;

  counter_sweep_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .start_val (start_val),
    .end_val   (end_val),
    .pause_i   (pause_i),
    .abort_i   (abort_i),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .count_o   (count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents a job and returns in cycle 1.
  task automatic launch(input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] ev);
    start_val = sv;
    end_val   = ev;
    start_i   = 1'b1;
    next_cyc();
    start_i   = 1'b0;
  endtask

  // Steps until done is seen or the cycle budget runs out; -1 on timeout.
  task automatic wait_done(input int cur, input int max, output int dc);
    int c;
    c = cur;
    while (done !== 1'b1 && c < max) begin
      next_cyc();
      c++;
    end
    dc = (done === 1'b1) ? c : -1;
  endtask

  initial begin
    int dc;
    rst       = 1'b1;
    start_i   = 1'b0;
    start_val = '0;
    end_val   = '0;
    pause_i   = 1'b0;
    abort_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset count", count_o, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset done", done, 0);
    check_eq("reset aborted", aborted, 0);
    rst = 1'b0;
    next_cyc();

    // 1. Up sweep 10 -> 14
    launch(8'h10, 8'h14);
    check_eq("up c1 busy", busy, 1);
    for (int c = 2; c <= 6; c++) begin
      next_cyc();
      check_eq($sformatf("up c%0d count", c), count_o, 'h10 + c - 2);
      check_eq($sformatf("up c%0d busy", c), busy, 1);
      check_eq($sformatf("up c%0d done", c), done, 0);
    end
    next_cyc();
    check_eq("up c7 done", done, 1);
    check_eq("up c7 busy", busy, 0);
    check_eq("up c7 count", count_o, 'h14);
    next_cyc();
    check_eq("up c8 done", done, 0);
    check_eq("up c8 count hold", count_o, 'h14);

    // 2. Down sweep 05 -> 02
    launch(8'h05, 8'h02);
    for (int c = 2; c <= 5; c++) begin
      next_cyc();
      check_eq($sformatf("down c%0d count", c), count_o, 'h05 - (c - 2));
      check_eq($sformatf("down c%0d inc", c), dut.cnt_inc, 0);
      check_eq($sformatf("down c%0d done", c), done, 0);
    end
    next_cyc();
    check_eq("down c6 done", done, 1);
    check_eq("down c6 count", count_o, 'h02);
    next_cyc();

    // Abort in IDLE together with start: counter cleared, start lost, silent
    abort_i   = 1'b1;
    start_i   = 1'b1;
    start_val = 8'h50;
    end_val   = 8'h60;
    next_cyc();
    abort_i = 1'b0;
    start_i = 1'b0;
    check_eq("idle abort count", count_o, 0);
    check_eq("idle abort busy", busy, 0);
    check_eq("idle abort aborted", aborted, 0);
    next_cyc();
    check_eq("idle abort start lost", busy, 0);

    // 3. Equal 7F -> 7F
    launch(8'h7F, 8'h7F);
    check_eq("eq c1 en", dut.cnt_en, 0);
    next_cyc();
    check_eq("eq c2 en", dut.cnt_en, 0);
    check_eq("eq c2 done", done, 0);
    next_cyc();
    check_eq("eq c3 done", done, 1);
    check_eq("eq c3 count", count_o, 'h7F);
    next_cyc();

    // 4. Extremes
    launch(8'h00, 8'hFF);
    wait_done(1, 400, dc);
    check_eq("ext up done cycle", dc, 258);
    check_eq("ext up count", count_o, 'hFF);
    next_cyc();
    launch(8'hFF, 8'h00);
    wait_done(1, 400, dc);
    check_eq("ext down done cycle", dc, 258);
    check_eq("ext down count", count_o, 'h00);
    next_cyc();

    // 5. Pause for cycles 3..5 of a 20 -> 24 sweep
    launch(8'h20, 8'h24);
    next_cyc();
    check_eq("pause c2 count", count_o, 'h20);
    next_cyc();
    check_eq("pause c3 count", count_o, 'h21);
    pause_i = 1'b1;
    next_cyc();
    check_eq("pause c4 count", count_o, 'h21);
    next_cyc();
    check_eq("pause c5 count", count_o, 'h21);
    next_cyc();
    pause_i = 1'b0;
    check_eq("pause c6 count", count_o, 'h21);
    wait_done(6, 40, dc);
    check_eq("pause done cycle", dc, 10);
    check_eq("pause final count", count_o, 'h24);
    next_cyc();

    // 6a. Start during RUN ignored, then abort at count 12
    launch(8'h10, 8'h20);
    next_cyc();
    next_cyc();
    start_i   = 1'b1;
    start_val = 8'h80;
    end_val   = 8'h81;
    next_cyc();
    start_i = 1'b0;
    check_eq("run start ignored count", count_o, 'h12);
    check_eq("run busy before abort", busy, 1);
    abort_i = 1'b1;
    next_cyc();
    abort_i = 1'b0;
    check_eq("abort count cleared", count_o, 0);
    check_eq("abort pulse", aborted, 1);
    check_eq("abort busy", busy, 0);
    check_eq("abort no done", done, 0);
    next_cyc();
    check_eq("abort pulse ends", aborted, 0);
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      check_eq($sformatf("abort idle done %0d", c), done, 0);
      check_eq($sformatf("abort idle count %0d", c), count_o, 0);
    end

    // 6b. Asynchronous reset mid-cycle
    launch(8'h30, 8'h40);
    next_cyc();
    next_cyc();
    check_eq("pre-rst count", count_o, 'h31);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async rst count", count_o, 0);
    check_eq("async rst busy", busy, 0);
    check_eq("async rst done", done, 0);
    next_cyc();
    rst = 1'b0;
    next_cyc();
    check_eq("post-rst busy", busy, 0);
    check_eq("post-rst count", count_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
